ara_inval_buffer: RTL and testbench
===================================

Name: ara_inval_buffer

Overview:
- Buffers cache-line invalidation requests from the AXI invalidation filter before they reach CVA6's accelerator response port.
- Sits between the filter's inval_addr/inval_valid output and the acc_resp inval_valid/inval_addr fields consumed by the L1 D-cache.
- Decouples filter stalls from D-cache invalidation latency.
- Line-aligns addresses and merges duplicate requests to the same line while they wait.

Parameters:
- AddrWidth, 64, invalidation address width in bits.
- L1LineWidth, 16, L1 D-cache line size in bytes; power of two, >= 2.
- Depth, 4, number of buffer entries; power of two, >= 2.
- CntWidth, 16, width of the merge statistics counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- en_i  in  1  coherence enable, driven from acc_cons_en.
- in_addr_i  in  AddrWidth  invalidation address from the filter.
- in_valid_i  in  1  input valid.
- in_ready_o  out  1  input ready.
- out_addr_o  out  AddrWidth  line-aligned address to the D-cache.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  D-cache accepts the invalidation.
- count_o  out  $clog2(Depth)+1  number of occupied entries.
- merge_cnt_o  out  CntWidth  saturating count of merged requests.

Behaviour:
- Reset (asynchronous, any cycle, including mid-transfer):
  - all entries invalid; read and write pointers 0.
  - count_o=0, merge_cnt_o=0, out_valid_o=0, out_addr_o=0.
  - in_ready_o=1 in the first cycle after reset deasserts.
- Alignment: stored address = in_addr_i with the low $clog2(L1LineWidth) bits forced to 0.
- Storage: circular FIFO of Depth entries.
  - out_addr_o and out_valid_o come from registered head state; no combinational path from any input.
  - Push at edge N gives out_valid_o=1 from cycle N+1 when the FIFO was empty.
- Merge hit: the aligned input equals a valid entry other than the current head.
  - The head is excluded because the D-cache may be consuming it in the same cycle.
- in_ready_o = !en_i OR !full OR hit.
  - It never depends on out_ready_i.
  - A full FIFO with a simultaneous pop still deasserts ready for a non-hit input.
- Input handshake (in_valid_i && in_ready_o):
  - en_i=0: request dropped and not counted; existing entries keep draining.
  - en_i=1, hit: no new entry; merge_cnt_o increments, saturating at all-ones.
  - en_i=1, miss: written at the write pointer; write pointer increments with wrap mod Depth.
- Output handshake (out_valid_o && out_ready_i): head invalidated; read pointer increments with wrap.
- Simultaneous push and pop: count unchanged; both pointers advance.
  - When the FIFO held one entry, the new entry becomes head in the next cycle.
- Empty: out_valid_o=0; out_addr_o holds its last value.
- out_addr_o stays stable while out_valid_o=1 and out_ready_i=0 (AXI-style valid/ready rule).
- Order is preserved: invalidations leave in first-arrival order per line; merges never reorder.
- No state machine beyond FIFO occupancy.
  - count_o = write pointer minus read pointer, using an extra wrap bit.
  - full = (count_o == Depth); empty = (count_o == 0).

Decomposition:
- Put these in ara_pkg: inval_entry_t {logic valid; logic [AddrWidth-1:0] line_addr;} and the helper function line_align(addr, L1LineWidth).
- One sub-module: ara_inval_match.
  - Purely combinational Depth-way comparator.
  - Inputs: entries, head index, aligned input.
  - Output: hit.
- Everything else stays in ara_inval_buffer.

Test Plan:
- Push 0x8000_0013 with en_i=1 and out_ready_i=0 -> cycle +1: out_valid_o=1, out_addr_o=0x8000_0010, count_o=1.
- Push 0x100, 0x200, then 0x20C; out_ready_i=0 -> 0x20C merges into the 0x200 entry: count_o=2, merge_cnt_o=1. Release -> outputs 0x100 then 0x200.
- Push 0x100 twice while 0x100 is head -> no merge, count_o=2; D-cache sees 0x100 twice.
- Fill Depth=4 with 0x0, 0x10, 0x20, 0x30:
  - Input 0x40 -> in_ready_o=0.
  - Input 0x24 -> accepted as a merge, in_ready_o=1.
  - Pop one -> 0x40 accepted next cycle.
- en_i=0 with 2 entries queued, input 0x500 -> in_ready_o=1, dropped; the 2 queued entries drain; count_o reaches 0.
- Assert rst_i asynchronously mid-stream with 3 entries queued -> out_valid_o=0, count_o=0, merge_cnt_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ara_pkg.sv
// ---------------------------------------------------------------------------
// ara_pkg
// Shared types and helpers for the Ara invalidation buffer.
//   inval_entry_t : one buffer slot (valid flag + line-aligned address)
//   line_align()  : clears the byte-offset bits of an address for a given
//                   L1 line size in bytes (must be a power of two)
// InvalAddrWidth is the storage width of an entry; any AddrWidth used by the
// buffer must not exceed it.
// ---------------------------------------------------------------------------
package ara_pkg;

    localparam int unsigned InvalAddrWidth = 64;

    typedef struct packed {
        logic                      valid;
        logic [InvalAddrWidth-1:0] line_addr;
    } inval_entry_t;

    function automatic logic [InvalAddrWidth-1:0] line_align(
        input logic [InvalAddrWidth-1:0] addr,
        input int unsigned               line_bytes
    );
        logic [InvalAddrWidth-1:0] offset_mask;
        offset_mask = InvalAddrWidth'(line_bytes) - InvalAddrWidth'(1);
        return addr & ~offset_mask;
    endfunction

endpackage

// File: rtl/ara_inval_match.sv
// ---------------------------------------------------------------------------
// ara_inval_match
// Combinational Depth-way comparator: reports whether an aligned address is
// already held in a valid entry other than the head.
//   i_entries  : buffer contents
//   i_head_idx : index of the current head (excluded from matching, since the
//                D-cache may be consuming it in the same cycle)
//   i_addr     : line-aligned candidate address
//   o_hit      : 1 when a non-head valid entry holds i_addr
// ---------------------------------------------------------------------------
module ara_inval_match
    import ara_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  inval_entry_t              i_entries [Depth],
    input  logic [PtrW-1:0]           i_head_idx,
    input  logic [InvalAddrWidth-1:0] i_addr,
    output logic                      o_hit
);

    logic [Depth-1:0] w_match;

    generate
        for (genvar gi = 0; gi < Depth; gi++) begin : g_cmp
            assign w_match[gi] = i_entries[gi].valid
                              && (i_entries[gi].line_addr == i_addr)
                              && (i_head_idx != PtrW'(gi));
        end
    endgenerate

    assign o_hit = |w_match;

endmodule

// File: rtl/ara_inval_buffer.sv
// ---------------------------------------------------------------------------
// ara_inval_buffer
// Circular FIFO of cache-line invalidations between the AXI invalidation
// filter and the CVA6 L1 D-cache. Addresses are line-aligned on entry and a
// request for a line already waiting (other than the head) is merged.
//   clk_i / rst_i  : clock, asynchronous active-high reset
//   en_i           : coherence enable; when low, inputs are accepted & dropped
//   in_*           : valid/ready input from the filter
//   out_*          : valid/ready output to the D-cache (registered)
//   count_o        : occupied entries
//   merge_cnt_o    : saturating count of merged requests
// ---------------------------------------------------------------------------
module ara_inval_buffer
    import ara_pkg::*;
#(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned Depth       = 4,
    parameter int unsigned CntWidth    = 16,
    localparam int unsigned PtrW       = $clog2(Depth),
    localparam int unsigned CountW     = PtrW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] in_addr_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [AddrWidth-1:0] out_addr_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CountW-1:0]    count_o,
    output logic [CntWidth-1:0]  merge_cnt_o
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PtrW:0]          r_wr_ptr;
    logic [PtrW:0]          r_rd_ptr;
    inval_entry_t           r_entries [Depth];
    logic [AddrWidth-1:0]   r_out_addr;
    logic [CntWidth-1:0]    r_merge_cnt;

    logic [InvalAddrWidth-1:0] w_in_ext;
    logic [InvalAddrWidth-1:0] w_in_aligned;
    logic [PtrW-1:0]           w_wr_idx;
    logic [PtrW-1:0]           w_rd_idx;
    logic [PtrW-1:0]           w_rd_idx_next;
    logic [CountW-1:0]         w_count;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_hit;
    logic                      w_in_hs;
    logic                      w_push;
    logic                      w_merge;
    logic                      w_pop;

    assign w_in_ext      = InvalAddrWidth'(in_addr_i);
    assign w_in_aligned  = line_align(w_in_ext, L1LineWidth);
    assign w_wr_idx      = r_wr_ptr[PtrW-1:0];
    assign w_rd_idx      = r_rd_ptr[PtrW-1:0];
    assign w_rd_idx_next = w_rd_idx + 1'b1;
    assign w_count       = r_wr_ptr - r_rd_ptr;
    assign w_full        = (w_count == CountW'(Depth));
    assign w_empty       = (w_count == '0);

    ara_inval_match #(
        .Depth (Depth)
    ) u_match (
        .i_entries  (r_entries),
        .i_head_idx (w_rd_idx),
        .i_addr     (w_in_aligned),
        .o_hit      (w_hit)
    );

    // A merge needs no free slot, so a hit is accepted even when full.
    assign in_ready_o = !en_i || !w_full || w_hit;
    assign w_in_hs    = in_valid_i && in_ready_o;
    assign w_push     = w_in_hs && en_i && !w_hit;
    assign w_merge    = w_in_hs && en_i && w_hit;
    assign w_pop      = !w_empty && out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_addr  <= '0;
            r_merge_cnt <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_merge && (r_merge_cnt != '1)) begin
                r_merge_cnt <= r_merge_cnt + 1'b1;
            end

            // Write and pop never target the same slot: a write lands on the
            // head slot only when the FIFO is empty, and then nothing pops.
            for (int i = 0; i < int'(Depth); i++) begin
                if (w_push && (int'(w_wr_idx) == i)) begin
                    r_entries[i].valid     <= 1'b1;
                    r_entries[i].line_addr <= w_in_aligned;
                end else if (w_pop && (int'(w_rd_idx) == i)) begin
                    r_entries[i].valid <= 1'b0;
                end
            end

            // Head address register: loads whatever becomes the head next
            // cycle and otherwise holds, so it keeps its last value when empty.
            if (w_push && (w_empty || (w_pop && (w_count == CountW'(1))))) begin
                r_out_addr <= w_in_aligned[AddrWidth-1:0];
            end else if (w_pop && (w_count > CountW'(1))) begin
                r_out_addr <= r_entries[w_rd_idx_next].line_addr[AddrWidth-1:0];
            end
        end
    end

    assign out_valid_o = !w_empty;
    assign out_addr_o  = r_out_addr;
    assign count_o     = w_count;
    assign merge_cnt_o = r_merge_cnt;

endmodule

// File: tb/tb_ara_inval_buffer.sv
// ---------------------------------------------------------------------------
// tb_ara_inval_buffer
// Directed scenarios plus a randomized run, checked against a queue-based
// reference model of the invalidation buffer.
// ---------------------------------------------------------------------------
module tb_ara_inval_buffer;

    localparam int DEPTH   = 4;
    localparam int CNT_MAX = 65535;

    logic        clk_i;
    logic        rst_i;
    logic        en_i;
    logic [63:0] in_addr_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] out_addr_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  count_o;
    logic [15:0] merge_cnt_o;

    ara_inval_buffer #(
        .AddrWidth   (64),
        .L1LineWidth (16),
        .Depth       (DEPTH),
        .CntWidth    (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .in_addr_i   (in_addr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_addr_o  (out_addr_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .merge_cnt_o (merge_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference model: pending lines in arrival order, merge count, last head.
    logic [63:0] mq[$];
    int          mcnt;
    logic [63:0] mlast;
    logic        exp_ready;
    logic        obs_ready;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_clear();
        mq.delete();
        mcnt  = 0;
        mlast = 64'h0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i       = 1'b1;
        en_i        = 1'b1;
        in_valid_i  = 1'b0;
        in_addr_i   = 64'h0;
        out_ready_i = 1'b0;
        model_clear();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One clock of stimulus; records model and DUT ready, advances the model.
    task automatic cycle(input logic en, input logic v, input logic [63:0] a, input logic rdy);
        logic [63:0] aligned;
        logic        hit;
        logic        pop;
        @(negedge clk_i);
        en_i        = en;
        in_valid_i  = v;
        in_addr_i   = a;
        out_ready_i = rdy;
        #1;
        aligned = a & ~64'hF;
        hit = 1'b0;
        for (int i = 1; i < mq.size(); i++) begin
            if (mq[i] == aligned) hit = 1'b1;
        end
        exp_ready = !en || (mq.size() < DEPTH) || hit;
        obs_ready = in_ready_o;
        pop = rdy && (mq.size() > 0);
        @(posedge clk_i);
        #1;
        if (pop) void'(mq.pop_front());
        if (v && exp_ready && en) begin
            if (hit) begin
                if (mcnt < CNT_MAX) mcnt++;
            end else begin
                mq.push_back(aligned);
            end
        end
        if (mq.size() > 0) mlast = mq[0];
        $display("[TB] t=%0t en=%0b v=%0b a=%h rdy=%0b -> in_ready=%0b out_v=%0b out_a=%h cnt=%0d merges=%0d",
                 $time, en, v, a, rdy, obs_ready, out_valid_o, out_addr_o, count_o, merge_cnt_o);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid_o); end
        n_tests++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        n_tests++; if (merge_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_merge: got %0d expected 0", merge_cnt_o); end
        n_tests++; if (out_addr_o !== 64'h0) begin n_fail++; $display("FAIL reset_out_addr: got %h expected 0", out_addr_o); end
        n_tests++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready_o); end
    endtask

    task automatic test_align();
        do_reset();
        cycle(1'b1, 1'b1, 64'h8000_0013, 1'b0);
        n_tests++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL align_valid: got %0b expected 1", out_valid_o); end
        n_tests++; if (out_addr_o !== 64'h8000_0010) begin n_fail++; $display("FAIL align_addr: got %h expected 0000000080000010", out_addr_o); end
        n_tests++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL align_count: got %0d expected 1", count_o); end
    endtask

    task automatic test_merge();
        do_reset();
        cycle(1'b1, 1'b1, 64'h100, 1'b0);
        cycle(1'b1, 1'b1, 64'h200, 1'b0);
        cycle(1'b1, 1'b1, 64'h20C, 1'b0);
        n_tests++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL merge_count: got %0d expected 2", count_o); end
        n_tests++; if (merge_cnt_o !== 16'd1) begin n_fail++; $display("FAIL merge_cnt: got %0d expected 1", merge_cnt_o); end
        n_tests++; if (out_addr_o !== 64'h100) begin n_fail++; $display("FAIL merge_first_out: got %h expected 100", out_addr_o); end
        cycle(1'b1, 1'b0, 64'h0, 1'b1);
        n_tests++; if (out_addr_o !== 64'h200) begin n_fail++; $display("FAIL merge_second_out: got %h expected 200", out_addr_o); end
        cycle(1'b1, 1'b0, 64'h0, 1'b1);
        n_tests++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL merge_drained_valid: got %0b expected 0", out_valid_o); end
        n_tests++; if (out_addr_o !== 64'h200) begin n_fail++; $display("FAIL merge_hold_addr: got %h expected 200", out_addr_o); end
    endtask

    task automatic test_head_no_merge();
        do_reset();
        cycle(1'b1, 1'b1, 64'h100, 1'b0);
        cycle(1'b1, 1'b1, 64'h100, 1'b0);
        n_tests++; if (count_o !== 3'd2) begin n_fail++; $display("FAIL head_count: got %0d expected 2", count_o); end
        n_tests++; if (merge_cnt_o !== 16'd0) begin n_fail++; $display("FAIL head_merge: got %0d expected 0", merge_cnt_o); end
        cycle(1'b1, 1'b0, 64'h0, 1'b1);
        n_tests++; if (out_addr_o !== 64'h100 || out_valid_o !== 1'b1) begin n_fail++; $display("FAIL head_second_copy: got v=%0b a=%h expected v=1 a=100", out_valid_o, out_addr_o); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 64'(i * 16), 1'b0);
        n_tests++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count_o); end
        cycle(1'b1, 1'b1, 64'h40, 1'b0);
        n_tests++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_miss: got %0b expected 0", obs_ready); end
        cycle(1'b1, 1'b1, 64'h24, 1'b0);
        n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_hit: got %0b expected 1", obs_ready); end
        n_tests++; if (merge_cnt_o !== 16'd1 || count_o !== 3'd4) begin n_fail++; $display("FAIL full_merge: got merges=%0d cnt=%0d expected 1 4", merge_cnt_o, count_o); end
        cycle(1'b1, 1'b1, 64'h40, 1'b1);
        n_tests++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready: got %0b expected 0", obs_ready); end
        cycle(1'b1, 1'b1, 64'h40, 1'b0);
        n_tests++; if (obs_ready !== 1'b1 || count_o !== 3'd4) begin n_fail++; $display("FAIL full_accept_after_pop: got rdy=%0b cnt=%0d expected 1 4", obs_ready, count_o); end
        for (int i = 1; i <= DEPTH; i++) begin
            n_tests++; if (out_addr_o !== 64'(i * 16)) begin n_fail++; $display("FAIL full_order: got %h expected %h", out_addr_o, 64'(i * 16)); end
            cycle(1'b1, 1'b0, 64'h0, 1'b1);
        end
        n_tests++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL full_drain_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_disable();
        do_reset();
        cycle(1'b1, 1'b1, 64'h300, 1'b0);
        cycle(1'b1, 1'b1, 64'h400, 1'b0);
        cycle(1'b0, 1'b1, 64'h500, 1'b1);
        n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL dis_ready: got %0b expected 1", obs_ready); end
        n_tests++; if (count_o !== 3'd1 || out_addr_o !== 64'h400) begin n_fail++; $display("FAIL dis_drain1: got cnt=%0d a=%h expected 1 400", count_o, out_addr_o); end
        cycle(1'b0, 1'b1, 64'h500, 1'b1);
        n_tests++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL dis_drain2: got cnt=%0d v=%0b expected 0 0", count_o, out_valid_o); end
        n_tests++; if (out_addr_o !== 64'h400) begin n_fail++; $display("FAIL dis_hold_addr: got %h expected 400", out_addr_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, 1'b1, 64'h1000, 1'b0);
        cycle(1'b1, 1'b1, 64'h2000, 1'b0);
        cycle(1'b1, 1'b1, 64'h2004, 1'b0);
        cycle(1'b1, 1'b1, 64'h3000, 1'b0);
        cycle(1'b1, 1'b0, 64'h0, 1'b0);
        n_tests++; if (count_o !== 3'd3 || merge_cnt_o !== 16'd1) begin n_fail++; $display("FAIL arst_pre: got cnt=%0d merges=%0d expected 3 1", count_o, merge_cnt_o); end
        #2;  // mid high phase, well away from any edge
        rst_i = 1'b1;
        model_clear();
        #1;
        n_tests++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b expected 0", out_valid_o); end
        n_tests++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", count_o); end
        n_tests++; if (merge_cnt_o !== 16'd0) begin n_fail++; $display("FAIL arst_merge: got %0d expected 0", merge_cnt_o); end
        n_tests++; if (out_addr_o !== 64'h0) begin n_fail++; $display("FAIL arst_addr: got %h expected 0", out_addr_o); end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        rst_i = 1'b0;
        #1;
        n_tests++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %0b expected 1", in_ready_o); end
    endtask

    task automatic test_random();
        logic [63:0] lines [6];
        logic [63:0] a;
        lines = '{64'h100, 64'h110, 64'h200, 64'h8000_0040, 64'h8000_0050, 64'hFFF0};
        do_reset();
        for (int n = 0; n < 400; n++) begin
            a = lines[$urandom_range(0, 5)] | 64'($urandom_range(0, 15));
            cycle(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, a, $urandom_range(0, 2) == 0);
            n_tests++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready: got %0b expected %0b", obs_ready, exp_ready); end
            n_tests++; if (out_valid_o !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid: got %0b expected %0b", out_valid_o, mq.size() > 0); end
            n_tests++; if (out_addr_o !== mlast) begin n_fail++; $display("FAIL rnd_addr: got %h expected %h", out_addr_o, mlast); end
            n_tests++; if (count_o !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", count_o, mq.size()); end
            n_tests++; if (merge_cnt_o !== 16'(mcnt)) begin n_fail++; $display("FAIL rnd_merge: got %0d expected %0d", merge_cnt_o, mcnt); end
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        en_i        = 1'b1;
        in_valid_i  = 1'b0;
        in_addr_i   = 64'h0;
        out_ready_i = 1'b0;
        model_clear();
        test_reset();
        test_align();
        test_merge();
        test_head_no_merge();
        test_full();
        test_disable();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
